// File: rtl/rca_pipe_param.sv
// Pipelined ripple-carry adder/subtractor, STAGE_BITS-wide slices per stage.
// Operands skew into the pipe and sum bits deskew so each result leaves aligned.
module rca_pipe_param #(
    parameter int WIDTH      = 16,
    parameter int STAGE_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / STAGE_BITS;
    localparam int LAST   = STAGES - 1;
    localparam int SB     = STAGE_BITS;

    if (STAGE_BITS < 1 || WIDTH % STAGE_BITS != 0) begin : g_bad_cfg
        $error("rca_pipe_param: WIDTH must be a multiple of STAGE_BITS");
    end

    logic             advance;
    logic [WIDTH-1:0] eff_b;
    logic             eff_c;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;
    assign eff_b    = b ^ {WIDTH{sub}};
    assign eff_c    = cin ^ sub;

    // Stage k holds the operand bits still to be added (slices k and up),
    // the carry into slice k and the sum bits already produced.
    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = k * SB;
        localparam int OW = WIDTH - LO;

        logic [OW-1:0]    a_r;
        logic [OW-1:0]    b_r;
        logic             c_r;
        logic             v_r;
        logic [SB-1:0]    sl;
        logic             co;
        logic [LO+SB-1:0] s_nxt;

        assign {co, sl} = {1'b0, a_r[SB-1:0]}
                        + {1'b0, b_r[SB-1:0]}
                        + {{SB{1'b0}}, c_r};

        if (k == 0) begin : g_first
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                    c_r <= 1'b0;
                    v_r <= 1'b0;
                end else if (advance) begin
                    a_r <= a;
                    b_r <= eff_b;
                    c_r <= eff_c;
                    v_r <= in_valid;
                end
            end
            assign s_nxt = sl;
        end else begin : g_rest
            logic [LO-1:0] s_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                    c_r <= 1'b0;
                    v_r <= 1'b0;
                    s_r <= '0;
                end else if (advance) begin
                    a_r <= g_stg[k-1].a_r[OW+SB-1:SB];
                    b_r <= g_stg[k-1].b_r[OW+SB-1:SB];
                    c_r <= g_stg[k-1].co;
                    v_r <= g_stg[k-1].v_r;
                    s_r <= g_stg[k-1].s_nxt;
                end
            end
            assign s_nxt = {sl, s_r};
        end
    end

    // Carry into the MSB is recovered from the MSB's own sum bit.
    logic msb_cin;

    assign msb_cin = g_stg[LAST].a_r[SB-1]
                   ^ g_stg[LAST].b_r[SB-1]
                   ^ g_stg[LAST].sl[SB-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (advance) begin
            out_valid <= g_stg[LAST].v_r;
            sum       <= g_stg[LAST].s_nxt;
            cout      <= g_stg[LAST].co;
            ovf       <= msb_cin ^ g_stg[LAST].co;
        end
    end

endmodule

// File: doc/rca_pipe_param.md
Name: rca_pipe_param

Overview:
- Parametrised pipelined ripple-carry adder/subtractor. Successor to the fixed 8-bit, 1-bit-per-stage pipelined RCA.
- The operand width splits into slices of STAGE_BITS. Each slice is a combinational ripple chain, and a register sits between adjacent slices on the carry.
- Adds add/subtract mode, carry/borrow-in, signed overflow, a valid/ready handshake with global stall, and synchronous reset.
- Sits in the datapath as a streaming arithmetic unit with one result per clock.

Parameters:
- WIDTH, 16: operand and result width in bits.
- STAGE_BITS, 4: bits per pipeline slice. WIDTH % STAGE_BITS must be 0, otherwise elaboration fails with an error.
- Derived: STAGES = WIDTH/STAGE_BITS. LATENCY = STAGES+1 clock edges, counting the capture edge.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- a  in  WIDTH  operand A, unsigned or two's complement
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add) or borrow-in (sub)
- sub  in  1  0 = add, 1 = subtract; sampled with the operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- sum  out  WIDTH  result
- cout  out  1  carry out of the MSB; in sub mode 1 means no borrow
- ovf  out  1  signed overflow

Behaviour:
- Arithmetic:
  - Effective B = b XOR {WIDTH{sub}}.
  - Effective carry-in = cin XOR sub.
  - sum = a + effB + effcin, modulo 2^WIDTH.
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR cout.
  - Consequences: sub=1, cin=0 gives a-b; sub=1, cin=1 gives a-b-1.
- Pipeline structure:
  - Stage 0 registers a, effB, effcin, valid.
  - Slice s (s = 0..STAGES-1) computes its STAGE_BITS sum bits from its operand bits and the registered carry out of slice s-1.
  - The slice s carry and sum bits register into stage s+1.
  - Operand bits of slice s are delayed s stages (input skew).
  - Sum bits of slice s are delayed STAGES-1-s further stages (output deskew), so all bits of one sample emerge together.
  - ovf is computed in the last slice and registered with cout.
  - Each stage carries a valid bit.
- Advance:
  - advance = !out_valid || out_ready.
  - All pipeline registers, including the delay lines, load only when advance=1. Otherwise every register holds.
  - in_ready = advance, a combinational function of out_valid and out_ready only, never of in_valid.
- Acceptance:
  - A sample is accepted at a rising edge where in_valid && in_ready.
  - When in_valid=0 and advance=1, a bubble (valid=0) enters stage 0.
- Latency and ordering:
  - A sample accepted at edge e with no stalls appears on sum/cout/ovf with out_valid=1 immediately after edge e+STAGES.
  - Each stall cycle adds exactly one cycle.
  - Results leave in acceptance order, with no loss or duplication.
- Throughput: 1 sample per clock while out_ready=1.
- Output stability: while out_valid=1 && out_ready=0, sum, cout, ovf and out_valid hold stable.
- Bubbles: a valid=0 slot never asserts out_valid. Data outputs under out_valid=0 are don't-care but must not be X after reset.
- Simultaneous events: when out_valid=1, out_ready=1 and in_valid=1 in the same cycle, the output retires and the input is accepted on that edge.
- Reset:
  - When rst=1 at an edge, all valid bits, data, carry and delay registers clear to 0.
  - After that edge: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
  - Reset dominates the handshake. In-flight samples are dropped, and an input presented in the reset cycle is not accepted.
- Degenerate configuration: STAGE_BITS=WIDTH gives STAGES=1 and LATENCY=2, with no skew or deskew registers.

Test Plan:
- Carry wrap: WIDTH=16, STAGE_BITS=4; a=0xFFFF, b=0x0001, cin=0, sub=0, accepted at edge e -> out_valid rises after edge e+4; sum=0x0000, cout=1, ovf=0.
- Subtract overflow: a=0x8000, b=0x0001, sub=1, cin=0 -> sum=0x7FFF, cout=1, ovf=1. Then a=0x0003, b=0x0005, sub=1, cin=1 -> sum=0xFFFD, cout=0, ovf=0.
- Streaming: 8 back-to-back samples, a=i*0x1111, b=0x0101, sub alternating 0/1, out_ready=1 -> 8 consecutive out_valid cycles starting at edge e0+4, with results in order and matching the model.
- Backpressure: pipeline full, out_ready=0 for 3 cycles -> in_ready=0 in those cycles, outputs frozen; after release the next results are exactly the expected sequence, with no gap beyond 3 cycles.
- Reset mid-stream: 3 samples in flight, rst=1 for one edge -> out_valid=0 and sum=0 after that edge, in_ready=1; the sample presented during reset never emerges; a post-reset sample has normal latency.
- Variant WIDTH=8, STAGE_BITS=8: a=0x12, b=0x43, cin=1 -> sum=0x56, cout=0, out_valid after edge e+1. Variant WIDTH=8, STAGE_BITS=1: latency 9 edges, matching 0x7F+0x01 -> sum=0x80, ovf=1.
